onchip_mem_arbiter: RTL and testbench
=====================================

// Module: onchip_mem_arbiter
// PURPOSE
//  Shares the single on-chip pattern/register memory port between two requesters:
//  - Port 0: register/control sequencer (polls and updates the 256-bit control word).
//  - Port 1: on-chip pattern streamer (bulk pattern reads).
//  Round-robin arbitration; the read tags are tracked in order so each returned read beat
//  is steered back to the port that issued it. Sits directly in front of the memory macro.
// PARAMETERS
//  ADDR_W           13   memory word address width
//  DATA_W           256  memory data width; BE_W = DATA_W/8 (derived localparam)
//  MAX_OUTSTANDING  4    max reads issued but not yet returned (tag FIFO depth, >=1)
// PORTS
//  clk              in   1       clock
//  rst_n            in   1       synchronous active-low reset
//  rN_req           in   1       N=0,1: command request; hold with cmd stable until rN_gnt
//  rN_wr            in   1       1=write, 0=read
//  rN_addr          in   ADDR_W  word address
//  rN_be            in   BE_W    byte enables (writes only)
//  rN_wdata         in   DATA_W  write data
//  rN_gnt           out  1       combinational: command accepted this cycle
//  rN_rvalid        out  1       read data valid for port N (1-cycle pulse per beat)
//  rN_rdata         out  DATA_W  read data for port N
//  mem_chip_select  out  1       memory select (high with read or write)
//  mem_clk_ena      out  1       tied 1
//  mem_read         out  1       read strobe
//  mem_write        out  1       write strobe
//  mem_addr         out  ADDR_W
//  mem_byte_enable  out  BE_W
//  mem_write_data   out  DATA_W
//  mem_read_valid   in   1       read data valid from memory (in issue order)
//  mem_read_data    in   DATA_W
//  err_rvalid_orphan out 1       sticky: mem_read_valid seen with no outstanding read
// BEHAVIOUR
//  Reset: all mem_* strobes/addr/be/wdata = 0, rN_rvalid = 0, rN_rdata = 0, err = 0,
//    outstanding = 0, tag FIFO empty, last_grant = 1 (port 0 wins the first tie).
//    mem_clk_ena = 1 at all times.
//  Eligibility: port N is eligible iff rN_req && (rN_wr || outstanding < MAX_OUTSTANDING).
//  Arbitration (combinational, same cycle): exactly one eligible -> grant it; both
//    eligible -> grant the port != last_grant; none -> no grant. At most one gnt per cycle.
//    last_grant updates on every grant. Back-to-back grants to the same port are allowed.
//  Issue: on the grant cycle edge, register the command onto mem_*; the strobe is high
//    exactly one cycle (cycle after gnt). chip_select = read|write. No grant -> strobes 0;
//    addr/be/wdata hold their last values.
//  Read tag: a granted read pushes its port id into the FIFO and increments outstanding.
//  Return: on mem_read_valid, pop the FIFO head; register mem_read_data into r<tag>_rdata
//    and pulse r<tag>_rvalid the next cycle (1 cycle latency). Other port's rvalid = 0,
//    its rdata holds its value.
//  Simultaneous push + pop: FIFO advances both ends, outstanding unchanged.
//  Full: when outstanding == MAX_OUTSTANDING, reads are not granted; writes still are.
//  Orphan: mem_read_valid with an empty FIFO -> beat dropped, no rvalid, err set until reset.
//  Reset mid-operation: pending tags are discarded; late beats follow the orphan rule.
//  Counter width: $clog2(MAX_OUTSTANDING+1); the FIFO pointers wrap modulo MAX_OUTSTANDING.
// TESTING
//  1 Reset, then r0 read addr 0 alone -> r0_gnt same cycle; mem_read=1, addr=0 next cycle;
//    memory returns 0xA5.. -> r0_rvalid 1 cycle after mem_read_valid, r0_rdata=0xA5..
//  2 Both req reads held 6 cycles -> grants alternate 0,1,0,1 starting with port 0; rdata
//    tagged 0xAAAA/0xBBBB is routed to the matching port in order.
//  3 r1 issues 4 reads with no return (MAX_OUTSTANDING=4) -> 5th read not granted; r0 write
//    be=32'h40000000 granted; one mem_read_valid -> r1's pending read granted next cycle.
//  4 read_valid on the same cycle as a new grant -> outstanding unchanged, correct routing.
//  5 mem_read_valid with no outstanding reads -> no rvalid on either port; err sticks 1.
//  6 Assert rst_n=0 with 2 reads outstanding -> all outputs reset; subsequent requests
//    behave as in scenario 1.

Source files
------------

// File: rtl/onchip_mem_arbiter_if.sv
// Requester-side command/read-return bundle for onchip_mem_arbiter.
// The requester is the master and the arbiter is the slave.
interface onchip_mem_arbiter_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 256
);
    localparam int BE_W = DATA_W / 8;

    logic              req;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (output req, wr, addr, be, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, wr, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/onchip_mem_arbiter.sv
// Round-robin arbiter sharing one on-chip memory port between two requesters.
// Read beats return in issue order and are routed back through an in-order tag FIFO.
module onchip_mem_arbiter #(
    parameter int ADDR_W          = 13,
    parameter int DATA_W          = 256,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    onchip_mem_arbiter_if.slave r0,
    onchip_mem_arbiter_if.slave r1,
    output logic                mem_chip_select,
    output logic                mem_clk_ena,
    output logic                mem_read,
    output logic                mem_write,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W/8-1:0] mem_byte_enable,
    output logic [DATA_W-1:0]   mem_write_data,
    input  logic                mem_read_valid,
    input  logic [DATA_W-1:0]   mem_read_data,
    output logic                err_rvalid_orphan
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

    logic              last_grant;
    logic [CNT_W-1:0]  outstanding;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              tag_fifo [MAX_OUTSTANDING];

    logic              fifo_full;
    logic              fifo_empty;
    logic              elig0;
    logic              elig1;
    logic              gnt0;
    logic              gnt1;
    logic              any_gnt;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [BE_W-1:0]   sel_be;
    logic [DATA_W-1:0] sel_wdata;
    logic              push;
    logic              pop;
    logic              head_tag;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign fifo_full  = (outstanding == MAX_CNT);
    assign fifo_empty = (outstanding == '0);

    // Writes never occupy a tag slot, so a full tag FIFO only blocks reads.
    assign elig0 = r0.req && (r0.wr || !fifo_full);
    assign elig1 = r1.req && (r1.wr || !fifo_full);

    // On a tie the port that did not win last time is granted.
    assign gnt0    = elig0 && (!elig1 || last_grant);
    assign gnt1    = elig1 && (!elig0 || !last_grant);
    assign any_gnt = gnt0 || gnt1;
    assign r0.gnt  = gnt0;
    assign r1.gnt  = gnt1;

    assign sel_wr    = gnt1 ? r1.wr    : r0.wr;
    assign sel_addr  = gnt1 ? r1.addr  : r0.addr;
    assign sel_be    = gnt1 ? r1.be    : r0.be;
    assign sel_wdata = gnt1 ? r1.wdata : r0.wdata;

    assign push     = any_gnt && !sel_wr;
    assign pop      = mem_read_valid && !fifo_empty;
    assign head_tag = tag_fifo[rd_ptr];

    assign mem_clk_ena = 1'b1;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant        <= 1'b1;
            outstanding       <= '0;
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            mem_chip_select   <= 1'b0;
            mem_read          <= 1'b0;
            mem_write         <= 1'b0;
            mem_addr          <= '0;
            mem_byte_enable   <= '0;
            mem_write_data    <= '0;
            r0.rvalid         <= 1'b0;
            r0.rdata          <= '0;
            r1.rvalid         <= 1'b0;
            r1.rdata          <= '0;
            err_rvalid_orphan <= 1'b0;
        end else begin
            if (any_gnt) begin
                last_grant      <= gnt1;
                mem_addr        <= sel_addr;
                mem_byte_enable <= sel_be;
                mem_write_data  <= sel_wdata;
            end
            mem_chip_select <= any_gnt;
            mem_read        <= push;
            mem_write       <= any_gnt && sel_wr;

            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            if (push && !pop)      outstanding <= outstanding + 1'b1;
            else if (pop && !push) outstanding <= outstanding - 1'b1;

            r0.rvalid <= pop && !head_tag;
            r1.rvalid <= pop && head_tag;
            if (pop && !head_tag) r0.rdata <= mem_read_data;
            if (pop && head_tag)  r1.rdata <= mem_read_data;

            if (mem_read_valid && fifo_empty) err_rvalid_orphan <= 1'b1;
        end
    end

    // NOTE: tag storage is not reset; entries are only read between push and pop,
    // and the pointers/count are reset, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) tag_fifo[wr_ptr] <= gnt1;
    end
endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench for onchip_mem_arbiter: arbitration order, tag routing, full/orphan
// handling and mid-operation reset, each compared against hand-computed values.
module tb_onchip_mem_arbiter;
    localparam int ADDR_W  = 13;
    localparam int DATA_W  = 256;
    localparam int BE_W    = DATA_W / 8;

    localparam logic [DATA_W-1:0] PAT_A5 = {32{8'hA5}};
    localparam logic [DATA_W-1:0] PAT_A  = {16{16'hAAAA}};
    localparam logic [DATA_W-1:0] PAT_B  = {16{16'hBBBB}};
    localparam logic [DATA_W-1:0] PAT_C  = {32{8'hCC}};
    localparam logic [DATA_W-1:0] PAT_D  = {32{8'hD0}};
    localparam logic [DATA_W-1:0] PAT_E  = {32{8'hEE}};
    localparam logic [DATA_W-1:0] PAT_F  = {32{8'hF1}};
    localparam logic [DATA_W-1:0] PAT_9  = {32{8'h99}};
    localparam logic [DATA_W-1:0] PAT_W  = {8{32'h1234_5678}};
    localparam logic [BE_W-1:0]   BE_W40 = 32'h4000_0000;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              mem_chip_select;
    logic              mem_clk_ena;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [BE_W-1:0]   mem_byte_enable;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_read_valid;
    logic [DATA_W-1:0] mem_read_data;
    logic              err_rvalid_orphan;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    onchip_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) r0_if ();
    onchip_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) r1_if ();

    onchip_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTSTANDING(4)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .r0                (r0_if),
        .r1                (r1_if),
        .mem_chip_select   (mem_chip_select),
        .mem_clk_ena       (mem_clk_ena),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .mem_addr          (mem_addr),
        .mem_byte_enable   (mem_byte_enable),
        .mem_write_data    (mem_write_data),
        .mem_read_valid    (mem_read_valid),
        .mem_read_data     (mem_read_data),
        .err_rvalid_orphan (err_rvalid_orphan)
    );

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " mem_cs"},    mem_chip_select,   0);
        check({tag, " mem_read"},  mem_read,          0);
        check({tag, " mem_write"}, mem_write,         0);
        check({tag, " mem_addr"},  mem_addr,          0);
        check({tag, " mem_be"},    mem_byte_enable,   0);
        check({tag, " mem_wdata"}, mem_write_data,    0);
        check({tag, " clk_ena"},   mem_clk_ena,       1);
        check({tag, " r0_rvalid"}, r0_if.rvalid,      0);
        check({tag, " r1_rvalid"}, r1_if.rvalid,      0);
        check({tag, " r0_rdata"},  r0_if.rdata,       0);
        check({tag, " r1_rdata"},  r1_if.rdata,       0);
        check({tag, " err"},       err_rvalid_orphan, 0);
    endtask

    // Lone r0 read of address 0 returning 0xA5.. with one cycle of routing latency.
    task automatic single_read_a5(input string tag);
        r0_if.req = 1'b1; r0_if.wr = 1'b0; r0_if.addr = '0;
        #1;
        check({tag, " r0_gnt"}, r0_if.gnt, 1);
        check({tag, " r1_gnt"}, r1_if.gnt, 0);
        tick();
        r0_if.req = 1'b0;
        check({tag, " mem_read"},  mem_read,        1);
        check({tag, " mem_cs"},    mem_chip_select, 1);
        check({tag, " mem_write"}, mem_write,       0);
        check({tag, " mem_addr"},  mem_addr,        0);
        check({tag, " early_rvalid"}, r0_if.rvalid, 0);
        mem_read_valid = 1'b1; mem_read_data = PAT_A5;
        tick();
        mem_read_valid = 1'b0;
        check({tag, " strobe_drop"}, mem_read,     0);
        check({tag, " r0_rvalid"},   r0_if.rvalid, 1);
        check({tag, " r0_rdata"},    r0_if.rdata,  PAT_A5);
        check({tag, " r1_rvalid"},   r1_if.rvalid, 0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        r0_if.req = 1'b0; r0_if.wr = 1'b0; r0_if.addr = '0; r0_if.be = '0; r0_if.wdata = '0;
        r1_if.req = 1'b0; r1_if.wr = 1'b0; r1_if.addr = '0; r1_if.be = '0; r1_if.wdata = '0;
        mem_read_valid = 1'b0; mem_read_data = '0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Scenario 1: single read from port 0.
        single_read_a5("s1");
        tick();
        check("s1 rvalid_pulse", r0_if.rvalid, 0);
        check("s1 rdata_hold",   r0_if.rdata,  PAT_A5);

        // Scenario 2: both ports hold reads; alternate grants until the tag FIFO fills.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        r0_if.req = 1'b1; r0_if.wr = 1'b0; r0_if.addr = 13'h010;
        r1_if.req = 1'b1; r1_if.wr = 1'b0; r1_if.addr = 13'h020;
        #1;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("s2 r0_gnt[%0d]", i), r0_if.gnt, (i < 4) && (i % 2 == 0));
            check($sformatf("s2 r1_gnt[%0d]", i), r1_if.gnt, (i < 4) && (i % 2 == 1));
            tick();
            check($sformatf("s2 mem_read[%0d]", i), mem_read, i < 4);
            if (i < 4)
                check($sformatf("s2 mem_addr[%0d]", i), mem_addr, (i % 2 == 1) ? 13'h020 : 13'h010);
        end
        r0_if.req = 1'b0;
        r1_if.req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_read_valid = 1'b1;
            mem_read_data  = (i % 2 == 1) ? PAT_B : PAT_A;
            tick();
            check($sformatf("s2 r0_rvalid[%0d]", i), r0_if.rvalid, i % 2 == 0);
            check($sformatf("s2 r1_rvalid[%0d]", i), r1_if.rvalid, i % 2 == 1);
            if (i % 2 == 0) check($sformatf("s2 r0_rdata[%0d]", i), r0_if.rdata, PAT_A);
            else            check($sformatf("s2 r1_rdata[%0d]", i), r1_if.rdata, PAT_B);
        end
        mem_read_valid = 1'b0;
        tick();
        check("s2 r0_quiet", r0_if.rvalid, 0);
        check("s2 r1_quiet", r1_if.rvalid, 0);

        // Scenario 3: port 1 fills the tag FIFO; writes still pass; one return frees a slot.
        r1_if.req = 1'b1; r1_if.wr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            r1_if.addr = 13'h100 + 13'(i);
            #1;
            check($sformatf("s3 r1_gnt[%0d]", i), r1_if.gnt, 1);
            tick();
        end
        r1_if.addr = 13'h104;
        #1;
        check("s3 full_blocks_read", r1_if.gnt, 0);
        r0_if.req = 1'b1; r0_if.wr = 1'b1; r0_if.addr = 13'h055; r0_if.be = BE_W40; r0_if.wdata = PAT_W;
        #1;
        check("s3 wr_gnt",      r0_if.gnt, 1);
        check("s3 rd_blocked",  r1_if.gnt, 0);
        tick();
        r0_if.req = 1'b0; r0_if.wr = 1'b0;
        check("s3 mem_write",   mem_write,       1);
        check("s3 mem_read",    mem_read,        0);
        check("s3 mem_cs",      mem_chip_select, 1);
        check("s3 mem_addr",    mem_addr,        13'h055);
        check("s3 mem_be",      mem_byte_enable, BE_W40);
        check("s3 mem_wdata",   mem_write_data,  PAT_W);
        mem_read_valid = 1'b1; mem_read_data = PAT_C;
        #1;
        check("s3 gnt_before_pop", r1_if.gnt, 0);
        tick();
        mem_read_valid = 1'b0;
        check("s3 r1_rvalid",   r1_if.rvalid, 1);
        check("s3 r1_rdata",    r1_if.rdata,  PAT_C);
        check("s3 gnt_after_pop", r1_if.gnt,  1);
        check("s3 write_pulse", mem_write,    0);
        tick();
        r1_if.req = 1'b0;
        check("s3 late_read",   mem_read, 1);
        check("s3 late_addr",   mem_addr, 13'h104);
        for (int i = 0; i < 4; i++) begin
            mem_read_valid = 1'b1;
            mem_read_data  = PAT_D + DATA_W'(i);
            tick();
            check($sformatf("s3 drain_r1_rvalid[%0d]", i), r1_if.rvalid, 1);
            check($sformatf("s3 drain_r1_rdata[%0d]", i),  r1_if.rdata,  PAT_D + DATA_W'(i));
            check($sformatf("s3 drain_r0_rvalid[%0d]", i), r0_if.rvalid, 0);
        end
        mem_read_valid = 1'b0;
        tick();
        check("s3 err_clear", err_rvalid_orphan, 0);

        // Scenario 4: a return coincides with a new grant; routing and count stay right.
        r0_if.req = 1'b1; r0_if.wr = 1'b0; r0_if.addr = 13'h033;
        #1;
        check("s4 r0_gnt", r0_if.gnt, 1);
        tick();
        r0_if.req = 1'b0;
        r1_if.req = 1'b1; r1_if.wr = 1'b0; r1_if.addr = 13'h044;
        mem_read_valid = 1'b1; mem_read_data = PAT_E;
        #1;
        check("s4 r1_gnt", r1_if.gnt, 1);
        tick();
        r1_if.req = 1'b0;
        mem_read_valid = 1'b0;
        check("s4 r0_rvalid", r0_if.rvalid, 1);
        check("s4 r0_rdata",  r0_if.rdata,  PAT_E);
        check("s4 r1_rvalid", r1_if.rvalid, 0);
        check("s4 mem_read",  mem_read,     1);
        check("s4 mem_addr",  mem_addr,     13'h044);
        mem_read_valid = 1'b1; mem_read_data = PAT_F;
        tick();
        mem_read_valid = 1'b0;
        check("s4 r1_rvalid2", r1_if.rvalid, 1);
        check("s4 r1_rdata2",  r1_if.rdata,  PAT_F);
        check("s4 r0_rvalid2", r0_if.rvalid, 0);
        check("s4 err",        err_rvalid_orphan, 0);

        // Scenario 5: a beat with nothing outstanding is dropped and flagged.
        mem_read_valid = 1'b1; mem_read_data = PAT_9;
        tick();
        mem_read_valid = 1'b0;
        check("s5 r0_rvalid", r0_if.rvalid, 0);
        check("s5 r1_rvalid", r1_if.rvalid, 0);
        check("s5 r1_rdata",  r1_if.rdata,  PAT_F);
        check("s5 err_set",   err_rvalid_orphan, 1);
        tick();
        check("s5 err_sticky", err_rvalid_orphan, 1);

        // Scenario 6: reset with two reads pending, then normal operation and a late beat.
        r0_if.req = 1'b1; r0_if.wr = 1'b0; r0_if.addr = 13'h077;
        r1_if.req = 1'b1; r1_if.wr = 1'b0; r1_if.addr = 13'h078;
        tick();
        tick();
        r0_if.req = 1'b0;
        r1_if.req = 1'b0;
        check("s6 pre_reset_read", mem_read, 1);
        rst_n = 1'b0;
        tick();
        check_reset_outputs("s6 reset");
        rst_n = 1'b1;
        single_read_a5("s6");
        mem_read_valid = 1'b1; mem_read_data = PAT_9;
        tick();
        mem_read_valid = 1'b0;
        check("s6 late_r0_rvalid", r0_if.rvalid, 0);
        check("s6 late_r1_rvalid", r1_if.rvalid, 0);
        check("s6 late_err",       err_rvalid_orphan, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
